// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control unit: opcode constants,
// ALU op codes, per-stage control bundles and the halt/drain FSM states.
// Build option: CTRL_FENCE_DRAIN_EN adds the FENCE_DRAIN state.
package riscv_ctrl_pkg;

  localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
  localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;
  localparam logic [4:0] OPCODE_FENCE   = 5'b00011;

  localparam int ALU_OP_W = 2;
  localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;  // address calc
  localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;  // branch compare
  localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;  // funct3/funct7 decides
  localparam logic [ALU_OP_W-1:0] ALUOP_LUI   = 2'b11;  // pass immediate

  typedef struct packed {
    logic                memread;
    logic                memtoreg;
    logic                memwrite;
    logic                alusrc;
    logic                regwrite;
    logic                branch;
    logic                jal;
    logic                jalr;
    logic                auipc;
    logic [ALU_OP_W-1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
`ifdef CTRL_FENCE_DRAIN_EN
    , ST_FENCE_DRAIN = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32I main decoder.
// Ports: opcode/funct3 in; ctrl bundle, source-register usage and
// halt/fence requests out. Build option: CTRL_FENCE_DRAIN_EN turns FENCE
// into a fence request instead of a plain NOP.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  output ctrl_t      ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       halt_req,
  output logic       fence_req
);

  always_comb begin
    ctrl      = '0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    halt_req  = 1'b0;
    fence_req = 1'b0;
    case (opcode)
      OPCODE_ARITH_R: begin
        ctrl.aluop    = ALUOP_FUNCT;
        ctrl.regwrite = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPCODE_ARITH_I: begin
        ctrl.aluop    = ALUOP_FUNCT;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OPCODE_LOAD: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OPCODE_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPCODE_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALUOP_SUB;
        uses_rs2    = 1'b1;
      end
      OPCODE_AUIPC: begin
        ctrl.auipc    = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs1      = 1'b0;
      end
      OPCODE_LUI: begin
        ctrl.aluop    = ALUOP_LUI;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs1      = 1'b0;
      end
      OPCODE_JAL: begin
        ctrl.jal      = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs1      = 1'b0;
      end
      OPCODE_JALR: begin
        ctrl.jalr     = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OPCODE_SYSTEM: halt_req = (funct3 == 3'd0);  // ECALL/EBREAK only
`ifdef CTRL_FENCE_DRAIN_EN
      OPCODE_FENCE:  fence_req = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipelined control unit: decodes IF/ID, carries controls through EX/MEM/WB,
// detects load-use hazards, squashes on taken branches and runs the
// ECALL/EBREAK halt-drain FSM.
// Ports: clk/rst_n (async low); id_valid/id_inst/ex_branch_taken in;
// stall/flush_if_id, ex_*/mem_*/wb_* stage controls and halted out.
// Build option: CTRL_FENCE_DRAIN_EN makes FENCE drain the pipe then resume.
module pipeline_ctrl_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 2,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [31:0]        id_inst,
  input  logic               ex_branch_taken,
  output logic               stall,
  output logic               flush_if_id,
  output logic               ex_valid,
  output logic               ex_memread,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic               ex_branch,
  output logic               ex_jal,
  output logic               ex_jalr,
  output logic               ex_auipc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [4:0]         ex_rd,
  output logic               mem_valid,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_memtoreg,
  output logic               mem_regwrite,
  output logic               wb_valid,
  output logic               wb_memtoreg,
  output logic               wb_regwrite,
  output logic               halted
);

  localparam int STAGES = 3;  // EX, MEM, WB

  ctrl_t     dec_ctrl, ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;
  logic [STAGES:1] vld_pipe;
  logic [4:0] ex_rd_q;
  logic uses_rs1, uses_rs2, halt_req, fence_req;
  logic hazard, accept, issue;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic unused_inst;
  assign unused_inst = ^{id_inst[31:25], id_inst[1:0]};

  ctrl_decoder u_dec (
    .opcode    (id_inst[6:2]),
    .funct3    (id_inst[14:12]),
    .ctrl      (dec_ctrl),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .halt_req  (halt_req),
    .fence_req (fence_req)
  );

  assign hazard = vld_pipe[1] & ex_q.memread & (ex_rd_q != 5'd0) &
                  ((uses_rs1 & (ex_rd_q == id_inst[19:15])) |
                   (uses_rs2 & (ex_rd_q == id_inst[24:20])));

  // A branch squash wins over everything happening in ID.
  assign flush_if_id = ex_branch_taken;

  // State register and drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_RUN: begin
        if (accept & halt_req) begin
          state_nx = ST_DRAIN;
          cnt_nx   = 4'(DRAIN_DEPTH);
        end
`ifdef CTRL_FENCE_DRAIN_EN
        else if (accept & fence_req) begin
          state_nx = ST_FENCE_DRAIN;
          cnt_nx   = 4'(DRAIN_DEPTH);
        end
`endif
      end
      ST_DRAIN: begin
        if (cnt == 4'd0) state_nx = ST_HALTED;
        else             cnt_nx   = cnt - 4'd1;
      end
`ifdef CTRL_FENCE_DRAIN_EN
      // Leave on the 1->0 step so stall is already low when cnt reads 0.
      ST_FENCE_DRAIN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = ST_RUN;
      end
`endif
      default: ;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall  = 1'b0;
    halted = 1'b0;
    accept = 1'b0;
    case (state)
      ST_RUN: begin
        stall  = ~ex_branch_taken & hazard;
        accept = id_valid & ~ex_branch_taken & ~hazard;
      end
      ST_HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: stall = 1'b1;
    endcase
  end

  // Halt/fence requests are consumed by the FSM and enter EX as bubbles.
  assign issue = accept & ~halt_req & ~fence_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], issue};
      ex_q     <= issue ? dec_ctrl : '0;
      ex_rd_q  <= issue ? id_inst[11:7] : 5'd0;
      mem_q    <= '{memread: ex_q.memread, memwrite: ex_q.memwrite,
                    memtoreg: ex_q.memtoreg, regwrite: ex_q.regwrite};
      wb_q     <= '{memtoreg: mem_q.memtoreg, regwrite: mem_q.regwrite};
    end
  end

  assign ex_valid     = vld_pipe[1];
  assign ex_memread   = ex_q.memread;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_branch    = ex_q.branch;
  assign ex_jal       = ex_q.jal;
  assign ex_jalr      = ex_q.jalr;
  assign ex_auipc     = ex_q.auipc;
  assign ex_aluop     = ALUOP_W'(ex_q.aluop);
  assign ex_rd        = ex_rd_q;
  assign mem_valid    = vld_pipe[2];
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_memtoreg = mem_q.memtoreg;
  assign mem_regwrite = mem_q.regwrite;
  assign wb_valid     = vld_pipe[3];
  assign wb_memtoreg  = wb_q.memtoreg;
  assign wb_regwrite  = wb_q.regwrite;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Self-checking bench for pipeline_ctrl_unit: time-based behavioural model
// (halt/fence expressed as edge-count windows, stages as a 3-deep shift of
// expected bundles), a per-cycle compare process, and directed literal checks.
module tb_pipeline_ctrl_unit;

  localparam int D = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, ex_branch_taken;
  logic [31:0] id_inst;
  logic stall, flush_if_id, ex_valid, ex_memread, ex_memtoreg, ex_memwrite;
  logic ex_alusrc, ex_regwrite, ex_branch, ex_jal, ex_jalr, ex_auipc;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rd;
  logic mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic wb_valid, wb_memtoreg, wb_regwrite, halted;

  pipeline_ctrl_unit #(.ALUOP_W(2), .DRAIN_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_if_id(flush_if_id),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_auipc(ex_auipc),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd), .mem_valid(mem_valid),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
    .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, mr, mt, mw, as, rw, br, jal, jalr, auipc;
    logic [1:0] op;
    logic [4:0] rd;
  } mctl_t;

  typedef struct packed {
    mctl_t c;
    logic u1, u2, hr, fr;
  } dinfo_t;

  mctl_t m_ex, m_mem, m_wb;
  int m_cyc, m_halt_at, m_fence_until;
  int n_cmp = 0, n_mis = 0;
  bit run_chk = 1'b0;

  // Decode table written straight from the instruction-class list.
  function automatic dinfo_t spec_decode(logic [31:0] i);
    dinfo_t d;
    d = '0;
    d.c.v  = 1'b1;
    d.c.rd = i[11:7];
    d.u1   = 1'b1;
    case (i[6:2])
      5'b01100: begin d.c.op = 2'b10; d.c.rw = 1; d.u2 = 1; end
      5'b00100: begin d.c.op = 2'b10; d.c.as = 1; d.c.rw = 1; end
      5'b00000: begin d.c.mr = 1; d.c.mt = 1; d.c.as = 1; d.c.rw = 1; end
      5'b01000: begin d.c.mw = 1; d.c.as = 1; d.u2 = 1; end
      5'b11000: begin d.c.br = 1; d.c.op = 2'b01; d.u2 = 1; end
      5'b00101: begin d.c.auipc = 1; d.c.as = 1; d.c.rw = 1; d.u1 = 0; end
      5'b01101: begin d.c.op = 2'b11; d.c.as = 1; d.c.rw = 1; d.u1 = 0; end
      5'b11011: begin d.c.jal = 1; d.c.rw = 1; d.u1 = 0; end
      5'b11001: begin d.c.jalr = 1; d.c.as = 1; d.c.rw = 1; end
      5'b11100: d.hr = (i[14:12] == 3'd0);
`ifdef CTRL_FENCE_DRAIN_EN
      5'b00011: d.fr = 1'b1;
`endif
      default: ;
    endcase
    return d;
  endfunction

  function automatic void model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_cyc = 0; m_halt_at = -1; m_fence_until = 0;
  endfunction

  function automatic bit model_busy();
    return (m_halt_at >= 0) || (m_cyc < m_fence_until);
  endfunction

  function automatic bit model_halted();
    return (m_halt_at >= 0) && (m_cyc >= m_halt_at + D + 1);
  endfunction

  function automatic bit model_hazard();
    dinfo_t d;
    d = spec_decode(id_inst);
    return m_ex.v && m_ex.mr && (m_ex.rd != 0) &&
           ((d.u1 && m_ex.rd == id_inst[19:15]) || (d.u2 && m_ex.rd == id_inst[24:20]));
  endfunction

  function automatic bit model_stall();
    return model_busy() || (!ex_branch_taken && model_hazard());
  endfunction

  // Advance model across one active edge using the inputs held before it.
  function automatic void adv();
    dinfo_t d;
    mctl_t nx;
    bit acc;
    if (!rst_n) begin model_reset(); return; end
    d   = spec_decode(id_inst);
    acc = !model_busy() && !ex_branch_taken && !model_hazard() && id_valid;
    nx  = '0;
    m_cyc++;
    if (acc && d.hr)      m_halt_at = m_cyc;
    else if (acc && d.fr) m_fence_until = m_cyc + D;
    else if (acc)         nx = d.c;
    m_wb = m_mem; m_mem = m_ex; m_ex = nx;
  endfunction

  always @(negedge clk) if (run_chk) begin
    logic [27:0] e, a;
    e = {model_stall(), ex_branch_taken, model_halted(),
         m_ex.v, m_ex.mr, m_ex.mt, m_ex.mw, m_ex.as, m_ex.rw, m_ex.br, m_ex.jal,
         m_ex.jalr, m_ex.auipc, m_ex.op, m_ex.rd,
         m_mem.v, m_mem.mr, m_mem.mw, m_mem.mt, m_mem.rw, m_wb.v, m_wb.mt, m_wb.rw};
    a = {stall, flush_if_id, halted, ex_valid, ex_memread, ex_memtoreg, ex_memwrite,
         ex_alusrc, ex_regwrite, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_aluop, ex_rd,
         mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite,
         wb_valid, wb_memtoreg, wb_regwrite};
    n_cmp++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL cycle_outputs t=%0t: got %07h expected %07h", $time, a, e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] inst, input logic br);
    @(posedge clk);
    adv();
    #1;
    id_valid = v; id_inst = inst; ex_branch_taken = br;
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    id_valid = 1'b0; id_inst = '0; ex_branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] ops [12];
    logic [4:0] op;
    logic [2:0] f3;
    ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b00101,
            5'b01101, 5'b11011, 5'b11001, 5'b11100, 5'b00011, 5'b10110};
    op = ops[$urandom_range(0, 11)];
    f3 = 3'($urandom_range(0, 7));
    if (op == 5'b11100) begin
      if ($urandom_range(0, 9) != 0) op = 5'b00000;
      else if ($urandom_range(0, 1) == 0) f3 = 3'd0;
    end
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
            5'($urandom_range(0, 3)), op, 2'b11};
  endfunction

  localparam logic [31:0] LW5  = 32'h0000A283;  // lw  x5,0(x1)
  localparam logic [31:0] ADD6 = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] LW0  = 32'h0000A003;  // lw  x0,0(x1)
  localparam logic [31:0] ADD0 = 32'h00200333;  // add x6,x0,x2
  localparam logic [31:0] BEQ  = 32'h00208063;  // beq x1,x2,0
  localparam logic [31:0] SW   = 32'h0020A023;  // sw  x2,0(x1)
  localparam logic [31:0] ECAL = 32'h00000073;
  localparam logic [31:0] FENC = 32'h0000000F;
`ifdef CTRL_FENCE_DRAIN_EN
  localparam int FENCE_STALLS = 3;
  localparam logic FENCE_EXV = 1'b0;
`else
  localparam int FENCE_STALLS = 0;
  localparam logic FENCE_EXV = 1'b1;
`endif

  initial begin
    int scnt;
    rst_n = 1'b0;
    model_reset();
    id_valid = 1'b0; id_inst = '0; ex_branch_taken = 1'b0;
    run_chk = 1'b1;

    // Reset state and load-use stall
    do_reset();
    chk("reset_stall", 32'(stall), 0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_ex_valid", 32'(ex_valid), 0);
    cyc(1, LW5, 0);
    chk("lw_no_stall", 32'(stall), 0);
    cyc(1, ADD6, 0);
    chk("loaduse_stall", 32'(stall), 1);
    chk("lw_in_ex_rd", 32'(ex_rd), 5);
    cyc(1, ADD6, 0);
    chk("loaduse_stall_1cyc", 32'(stall), 0);
    chk("bubble_in_ex", 32'(ex_valid), 0);
    cyc(0, 32'h0, 0);
    chk("add_ex_valid", 32'(ex_valid), 1);
    chk("add_ex_aluop", 32'(ex_aluop), 2);
    chk("add_ex_rd", 32'(ex_rd), 6);

    // rd = x0 never hazards
    cyc(1, LW0, 0);
    cyc(1, ADD0, 0);
    chk("x0_no_stall", 32'(stall), 0);

    // Taken branch flushes a store in ID
    cyc(1, BEQ, 0);
    cyc(1, SW, 1);
    chk("flush", 32'(flush_if_id), 1);
    chk("flush_no_stall", 32'(stall), 0);
    cyc(0, 32'h0, 0);
    chk("flush_ex_memwrite", 32'(ex_memwrite), 0);
    cyc(0, 32'h0, 0);
    chk("flush_mem_memwrite", 32'(mem_memwrite), 0);

    // Taken branch squashes an ecall
    cyc(1, BEQ, 0);
    cyc(1, ECAL, 1);
    repeat (6) cyc(0, 32'h0, 0);
    chk("squash_halted", 32'(halted), 0);
    chk("squash_stall", 32'(stall), 0);

    // ecall: stall from accept edge, halted after DRAIN_DEPTH+1 edges
    cyc(1, LW5, 0);
    cyc(1, ECAL, 0);
    cyc(0, 32'h0, 0);
    chk("halt_stall_n", 32'(stall), 1);
    chk("halt_not_yet", 32'(halted), 0);
    repeat (D) cyc(0, 32'h0, 0);
    chk("halt_not_yet_n3", 32'(halted), 0);
    cyc(0, 32'h0, 0);
    chk("halted_n4", 32'(halted), 1);
    chk("halted_wb_valid", 32'(wb_valid), 0);
    chk("halted_wb_regwrite", 32'(wb_regwrite), 0);
    cyc(1, ADD6, 0);
    chk("halted_sticky", 32'(halted), 1);
    chk("halted_stall", 32'(stall), 1);

    // Reset in the middle of DRAIN
    do_reset();
    cyc(1, ECAL, 0);
    cyc(0, 32'h0, 0);
    cyc(0, 32'h0, 0);
    chk("drain_stall", 32'(stall), 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_stall", 32'(stall), 0);
    chk("midreset_halted", 32'(halted), 0);
    chk("midreset_mem_valid", 32'(mem_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // fence
    do_reset();
    cyc(1, FENC, 0);
    cyc(0, 32'h0, 0);
    chk("fence_ex_valid", 32'(ex_valid), 32'(FENCE_EXV));
    scnt = 32'(stall);
    repeat (6) begin
      cyc(0, 32'h0, 0);
      scnt += 32'(stall);
    end
    chk("fence_stall_cycles", 32'(scnt), 32'(FENCE_STALLS));

    // Randomised segments against the model
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        bit hold;
        hold = model_stall();
        @(posedge clk);
        adv();
        #1;
        if (!hold) begin
          id_valid = ($urandom_range(0, 7) != 0);
          id_inst  = rand_inst();
        end
        ex_branch_taken = m_ex.v && (m_ex.br || m_ex.jal || m_ex.jalr) &&
                          ($urandom_range(0, 1) == 1);
      end
    end

    @(posedge clk);
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
